// File: rtl/traffic_phase_scheduler.sv
// Round-robin green-phase scheduler for an N-approach intersection with min/max green,
// yellow and all-red timers. Define PED_WALK_EN to add the pedestrian walk phase.
module traffic_phase_scheduler #(
    parameter int NUM_DIR   = 4,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 8,
    parameter int YEL_CYC   = 2,
    parameter int RED_CYC   = 1,
    parameter int WALK_CYC  = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_DIR-1:0]         req,
`ifdef PED_WALK_EN
    input  logic                       ped_req,
    output logic                       walk,
`endif
    output logic [3*NUM_DIR-1:0]       lights,
    output logic [$clog2(NUM_DIR)-1:0] green_dir,
    output logic [1:0]                 phase,
    output logic [NUM_DIR-1:0]         pending
);

    localparam int          DW    = $clog2(NUM_DIR);
    localparam int unsigned ND    = NUM_DIR;
    localparam int          MAX_A = (MAX_GREEN > MIN_GREEN) ? MAX_GREEN : MIN_GREEN;
    localparam int          MAX_B = (MAX_A > YEL_CYC) ? MAX_A : YEL_CYC;
    localparam int          MAX_C = (MAX_B > RED_CYC) ? MAX_B : RED_CYC;
    localparam int          MAXC  = (MAX_C > WALK_CYC) ? MAX_C : WALK_CYC;
    localparam int          TW    = $clog2(MAXC) + 1;

    localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_YEL = TW'(YEL_CYC - 1);
    localparam logic [TW-1:0] T_RED = TW'(RED_CYC - 1);
`ifdef PED_WALK_EN
    localparam logic [TW-1:0] T_WALK = TW'(WALK_CYC - 1);
`endif

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2,
        PH_WALK    = 2'd3
    } phase_t;

    phase_t             state, state_n;
    logic [DW-1:0]      dir, dir_n, next_dir, idx_d;
    logic [TW-1:0]      timer, timer_n;
    logic [NUM_DIR-1:0] pend_q, pend_n, dir_mask;
    logic               others_pending, found;
    int unsigned        idx;
`ifdef PED_WALK_EN
    logic               ped_pend, ped_pend_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PH_GREEN;
            dir    <= '0;
            timer  <= '0;
            pend_q <= '0;
`ifdef PED_WALK_EN
            ped_pend <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            dir    <= dir_n;
            timer  <= timer_n;
            pend_q <= pend_n;
`ifdef PED_WALK_EN
            ped_pend <= ped_pend_n;
`endif
        end
    end

    assign dir_mask       = NUM_DIR'(1) << dir;
    assign others_pending = |(pend_q & ~dir_mask);

    // First pending approach after dir, wrapping round to dir itself last.
    always_comb begin
        next_dir = dir;
        found    = 1'b0;
        idx      = 0;
        idx_d    = '0;
        for (int unsigned k = 1; k <= ND; k++) begin
            idx = 32'(dir) + k;
            if (idx >= ND) idx = idx - ND;
            idx_d = DW'(idx);
            if (!found && pend_q[idx_d]) begin
                next_dir = idx_d;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        pend_n  = pend_q | (req & ~((state == PH_GREEN) ? dir_mask : '0));
`ifdef PED_WALK_EN
        ped_pend_n = ped_pend | ped_req;
`endif
        case (state)
            PH_GREEN: begin
`ifdef PED_WALK_EN
                if (timer >= T_MIN &&
                    ((others_pending && (!req[dir] || timer == T_MAX)) || ped_pend))
                    state_n = PH_YELLOW;
`else
                if (timer >= T_MIN && others_pending && (!req[dir] || timer == T_MAX))
                    state_n = PH_YELLOW;
`endif
            end
            PH_YELLOW: begin
                if (timer == T_YEL) state_n = PH_ALL_RED;
            end
            PH_ALL_RED: begin
                if (timer == T_RED) begin
`ifdef PED_WALK_EN
                    if (ped_pend) begin
                        state_n    = PH_WALK;
                        ped_pend_n = 1'b0;
                    end else begin
                        state_n          = PH_GREEN;
                        dir_n            = next_dir;
                        pend_n[next_dir] = 1'b0;
                    end
`else
                    state_n          = PH_GREEN;
                    dir_n            = next_dir;
                    pend_n[next_dir] = 1'b0;
`endif
                end
            end
`ifdef PED_WALK_EN
            PH_WALK: begin
                if (timer == T_WALK) state_n = PH_ALL_RED;
            end
`endif
            default: state_n = PH_GREEN;
        endcase

        // Green saturates at the cap so a long rest can never wrap and re-arm the max check.
        if (state_n != state)
            timer_n = '0;
        else if (state == PH_GREEN && timer == T_MAX)
            timer_n = timer;
        else
            timer_n = timer + TW'(1);
    end

    always_comb begin
        lights = {NUM_DIR{3'b100}};
        for (int unsigned i = 0; i < ND; i++) begin
            if (DW'(i) == dir) begin
                if (state == PH_GREEN)       lights[3*i +: 3] = 3'b001;
                else if (state == PH_YELLOW) lights[3*i +: 3] = 3'b010;
            end
        end
    end

    assign green_dir = dir;
    assign phase     = state;
    assign pending   = pend_q;
`ifdef PED_WALK_EN
    assign walk      = (state == PH_WALK);
`endif

endmodule
